// File: rtl/alu_ac_unit.sv
`default_nettype none
// ============================================================================
// alu_ac_unit : accumulator ALU with E link flag; optional MUL via ALU_MUL_EN
// Rev 1.0
// ============================================================================
module alu_ac_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_code,
  input  logic             cin,
  input  logic [WIDTH-1:0] dr,
  output logic [WIDTH-1:0] ac,
  output logic             e,
  output logic             done,
  output logic             zero,
  output logic             neg,
  output logic             illegal
);

  localparam logic [3:0] c_OP_NOP = 4'd0;
  localparam logic [3:0] c_OP_AND = 4'd1;
  localparam logic [3:0] c_OP_ADD = 4'd2;
  localparam logic [3:0] c_OP_LDA = 4'd3;
  localparam logic [3:0] c_OP_OR  = 4'd4;
  localparam logic [3:0] c_OP_CMA = 4'd5;
  localparam logic [3:0] c_OP_CLA = 4'd6;
  localparam logic [3:0] c_OP_CLE = 4'd7;
  localparam logic [3:0] c_OP_CME = 4'd8;
  localparam logic [3:0] c_OP_CIR = 4'd9;
  localparam logic [3:0] c_OP_CIL = 4'd10;
  localparam logic [3:0] c_OP_INC = 4'd11;
  localparam logic [3:0] c_OP_MUL = 4'd12;

  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH-1:0] w_ac_nxt;
  logic             w_e_nxt;
  logic             w_illegal;
  logic             w_start_mul;

  assign w_accept = op_valid & op_ready;
  assign zero     = (ac == '0);
  assign neg      = ac[WIDTH-1];

  always_comb begin
    w_sum       = {1'b0, ac} + {1'b0, dr} + {{WIDTH{1'b0}}, cin};
    w_inc       = {1'b0, ac} + {{WIDTH{1'b0}}, 1'b1};
    w_ac_nxt    = ac;
    w_e_nxt     = e;
    w_illegal   = 1'b0;
    w_start_mul = 1'b0;
    case (op_code)
      c_OP_NOP: ;
      c_OP_AND: w_ac_nxt = ac & dr;
      c_OP_ADD: {w_e_nxt, w_ac_nxt} = w_sum;
      c_OP_LDA: w_ac_nxt = dr;
      c_OP_OR:  w_ac_nxt = ac | dr;
      c_OP_CMA: w_ac_nxt = ~ac;
      c_OP_CLA: w_ac_nxt = '0;
      c_OP_CLE: w_e_nxt  = 1'b0;
      c_OP_CME: w_e_nxt  = ~e;
      c_OP_CIR: begin
        w_e_nxt  = ac[0];
        w_ac_nxt = {e, ac[WIDTH-1:1]};
      end
      c_OP_CIL: begin
        w_e_nxt  = ac[WIDTH-1];
        w_ac_nxt = {ac[WIDTH-2:0], e};
      end
      c_OP_INC: {w_e_nxt, w_ac_nxt} = w_inc;
`ifdef ALU_MUL_EN
      c_OP_MUL: w_start_mul = 1'b1;
`else
      c_OP_MUL: w_illegal = 1'b1;
`endif
      default:  w_illegal = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_MUL_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH:0]     w_mul_add;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic               w_mul_last;

  // {A,Q} shift-add: Q starts as the multiplier, A accumulates, then shift right
  always_comb begin
    w_mul_add   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    w_prod_nxt  = {w_mul_add, r_prod[WIDTH-1:1]};
    w_mul_last  = (r_state == S_MUL_BUSY) && (r_cnt == CW'(WIDTH - 1));
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_accept && w_start_mul) w_state_nxt = S_MUL_BUSY;
      S_MUL_BUSY: if (w_mul_last) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_mcand <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && w_start_mul) begin
        r_prod  <= {{WIDTH{1'b0}}, dr};
        r_mcand <= ac;
        r_cnt   <= '0;
      end else if (r_state == S_MUL_BUSY) begin
        r_prod <= w_prod_nxt;
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  assign op_ready = (r_state == S_IDLE);
`else
  assign op_ready = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac      <= '0;
      e       <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      if (w_accept) begin
        ac      <= w_ac_nxt;
        e       <= w_e_nxt;
        illegal <= w_illegal;
        done    <= ~w_start_mul;
      end
`ifdef ALU_MUL_EN
      else if (w_mul_last) begin
        ac   <= w_prod_nxt[WIDTH-1:0];
        e    <= |w_prod_nxt[2*WIDTH-1:WIDTH];
        done <= 1'b1;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_ac_unit.sv
`default_nettype none
// ============================================================================
// tb_alu_ac_unit : directed scoreboard bench for alu_ac_unit (WIDTH = 8)
// Rev 1.0
// ============================================================================
module tb_alu_ac_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [3:0]   op_code = 4'd0;
  logic         cin = 1'b0;
  logic [W-1:0] dr = '0;
  logic [W-1:0] ac;
  logic         e;
  logic         done;
  logic         zero;
  logic         neg;
  logic         illegal;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] m_ac = '0;
  logic         m_e = 1'b0;

  typedef struct {
    logic [W-1:0] ac;
    logic         e;
    logic         ill;
    int           lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_ac_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_code  (op_code),
    .cin      (cin),
    .dr       (dr),
    .ac       (ac),
    .e        (e),
    .done     (done),
    .zero     (zero),
    .neg      (neg),
    .illegal  (illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation, push the reference result, then pop and compare on done.
  // With hold set, op_valid stays high (as an LDA 0x55) while the unit is busy.
  task automatic do_op(input logic [3:0] code, input logic [W-1:0] d, input logic c,
                       input logic hold, input string tag);
    exp_t           x;
    exp_t           got;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    int             lat;
    int             busy;
    @(negedge clk);
    chk({tag, "_ready_in"}, op_ready, 1);
    op_valid = 1'b1;
    op_code  = code;
    dr       = d;
    cin      = c;
    x.ac = m_ac; x.e = m_e; x.ill = 1'b0; x.lat = 1;
    case (code)
      4'd0:  ;
      4'd1:  x.ac = m_ac & d;
      4'd2:  begin s = m_ac + d + c; x.e = s[W]; x.ac = s[W-1:0]; end
      4'd3:  x.ac = d;
      4'd4:  x.ac = m_ac | d;
      4'd5:  x.ac = ~m_ac;
      4'd6:  x.ac = '0;
      4'd7:  x.e = 1'b0;
      4'd8:  x.e = ~m_e;
      4'd9:  begin x.e = m_ac[0]; x.ac = {m_e, m_ac[W-1:1]}; end
      4'd10: begin x.e = m_ac[W-1]; x.ac = {m_ac[W-2:0], m_e}; end
      4'd11: begin s = m_ac + 1; x.e = s[W]; x.ac = s[W-1:0]; end
`ifdef ALU_MUL_EN
      4'd12: begin p = m_ac * d; x.ac = p[W-1:0]; x.e = |p[2*W-1:W]; x.lat = W + 1; end
`endif
      default: x.ill = 1'b1;
    endcase
    m_ac = x.ac;
    m_e  = x.e;
    sb.push_back(x);
    @(posedge clk); #1;
    if (hold) begin
      op_code = 4'd3;
      dr      = 8'h55;
    end else begin
      op_valid = 1'b0;
      dr       = W'($urandom);
      cin      = 1'($urandom);
    end
    lat  = 1;
    busy = 0;
    while (!done && lat < W + 4) begin
      if (!op_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    op_valid = 1'b0;
    got = sb.pop_front();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_latency"}, lat, got.lat);
    chk({tag, "_busy_cycles"}, busy, got.lat - 1);
    chk({tag, "_ready_out"}, op_ready, 1);
    chk({tag, "_ac"}, ac, got.ac);
    chk({tag, "_e"}, e, got.e);
    chk({tag, "_illegal"}, illegal, got.ill);
    chk({tag, "_zero"}, zero, (got.ac == '0));
    chk({tag, "_neg"}, neg, got.ac[W-1]);
  endtask

  initial begin
    int pulses;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ac", ac, 0);
    chk("rst_e", e, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", op_ready, 1);
    chk("rst_zero", zero, 1);
    chk("rst_neg", neg, 0);

    // LDA then ADD with carry in
    do_op(4'd3, 8'hF0, 1'b0, 1'b0, "lda_f0");
    do_op(4'd2, 8'h20, 1'b1, 1'b0, "add_20");
    chk("add_ac_const", ac, 8'h11);
    chk("add_e_const", e, 1);

    // rotates through E
    do_op(4'd3, 8'h81, 1'b0, 1'b0, "lda_81");
    do_op(4'd7, 8'h00, 1'b0, 1'b0, "cle");
    do_op(4'd10, 8'h3C, 1'b1, 1'b0, "cil");
    chk("cil_ac_const", ac, 8'h02);
    chk("cil_e_const", e, 1);
    do_op(4'd9, 8'hC3, 1'b0, 1'b0, "cir");
    chk("cir_ac_const", ac, 8'h81);
    chk("cir_e_const", e, 0);

    // INC wrap and complement
    do_op(4'd3, 8'hFF, 1'b0, 1'b0, "lda_ff");
    do_op(4'd11, 8'h12, 1'b1, 1'b0, "inc");
    chk("inc_zero_const", zero, 1);
    chk("inc_e_const", e, 1);
    do_op(4'd5, 8'h00, 1'b0, 1'b0, "cma");
    chk("cma_neg_const", neg, 1);
    chk("cma_e_const", e, 1);

    // logic ops leave E alone
    do_op(4'd1, 8'h5A, 1'b0, 1'b0, "and");
    do_op(4'd4, 8'h81, 1'b0, 1'b0, "or");
    do_op(4'd8, 8'h00, 1'b0, 1'b0, "cme");
    do_op(4'd6, 8'h77, 1'b0, 1'b0, "cla");
    do_op(4'd3, 8'h96, 1'b0, 1'b0, "lda_96");
    do_op(4'd0, 8'hFF, 1'b1, 1'b0, "nop");
    do_op(4'd2, 8'h7F, 1'b0, 1'b0, "add_7f");

    // done and illegal drop after a single pulse
    @(posedge clk); #1;
    chk("pulse_done_low", done, 0);
    chk("pulse_illegal_low", illegal, 0);

    // unsupported codes
    do_op(4'd14, 8'h00, 1'b0, 1'b0, "ill_14");
    do_op(4'd13, 8'hFF, 1'b1, 1'b0, "ill_13");
    do_op(4'd15, 8'h01, 1'b0, 1'b0, "ill_15");
    @(posedge clk); #1;
    chk("ill_pulse_low", illegal, 0);

`ifdef ALU_MUL_EN
    do_op(4'd3, 8'h0C, 1'b0, 1'b0, "lda_0c");
    do_op(4'd12, 8'h0B, 1'b0, 1'b1, "mul_0c_0b");
    chk("mul1_ac_const", ac, 8'h84);
    chk("mul1_e_const", e, 0);
    do_op(4'd3, 8'h20, 1'b0, 1'b0, "lda_20");
    do_op(4'd12, 8'h10, 1'b0, 1'b1, "mul_20_10");
    chk("mul2_ac_const", ac, 8'h00);
    chk("mul2_e_const", e, 1);
    do_op(4'd3, 8'hFF, 1'b0, 1'b0, "lda_ff2");
    do_op(4'd12, 8'hFF, 1'b0, 1'b0, "mul_ff_ff");
    do_op(4'd3, 8'hAA, 1'b0, 1'b0, "after_mul");
`else
    do_op(4'd12, 8'h0B, 1'b0, 1'b0, "ill_12");
`endif

    // asynchronous reset, mid-MUL when the multiplier is present
    do_op(4'd3, 8'h0C, 1'b0, 1'b0, "lda_pre_rst");
    do_op(4'd8, 8'h00, 1'b0, 1'b0, "cme_pre_rst");
`ifdef ALU_MUL_EN
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = 4'd12;
    dr       = 8'h03;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("midmul_ready_low", op_ready, 0);
`else
    @(posedge clk);
    #3;
`endif
    rst_n = 1'b0;
    #1;
    chk("arst_ac", ac, 0);
    chk("arst_e", e, 0);
    chk("arst_done", done, 0);
    chk("arst_ready", op_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ac  = '0;
    m_e   = 1'b0;
    pulses = 0;
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("arst_no_done", pulses, 0);
    chk("arst_ready_after", op_ready, 1);
    do_op(4'd2, 8'h05, 1'b1, 1'b0, "add_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
